// File: rtl/loader_pkg.sv
// Shared definitions for the program memory loader: FSM encoding and image/word geometry.
package loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_COUNT_HI,
    ST_COUNT_LO,
    ST_DATA,
    ST_CHECK,
    ST_DONE,
    ST_ERROR
  } state_e;

  localparam int          BYTES_PER_WORD       = 4;
  localparam logic [31:0] DEFAULT_BASE_ADDRESS = 32'h0040_0000;

endpackage

// File: rtl/program_memory_loader_assembler.sv
// Packs a big-endian byte stream into words; emits each finished word with a one-cycle valid pulse.
module byte_word_assembler
  import loader_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear_i,
  input  logic                  byte_valid_i,
  input  logic [7:0]            byte_i,
  output logic                  last_byte_o,
  output logic                  word_valid_o,
  output logic [DATA_WIDTH-1:0] word_o
);

  logic [1:0]            cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [DATA_WIDTH-1:0] word_q, word_d;
  logic                  valid_q, valid_d;

  assign last_byte_o  = (cnt_q == 2'(BYTES_PER_WORD - 1));
  assign word_valid_o = valid_q;
  assign word_o       = word_q;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    cnt_d   = cnt_q;
    shift_d = shift_q;
    word_d  = word_q;
    valid_d = 1'b0;
    if (clear_i) begin
      cnt_d   = '0;
      shift_d = '0;
    end else if (byte_valid_i) begin
      shift_d = {shift_q[DATA_WIDTH-9:0], byte_i};
      cnt_d   = cnt_q + 2'd1;
      if (last_byte_o) begin
        word_d  = shift_d;
        valid_d = 1'b1;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q   <= '0;
      shift_q <= '0;
      word_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      word_q  <= word_d;
      valid_q <= valid_d;
    end
  end

endmodule

// File: rtl/program_memory_loader.sv
// Loads a checksummed program image from a byte stream into program memory, holding the CPU in reset.
module program_memory_loader
  import loader_pkg::*;
#(
  parameter int          MEMORY_DEPTH = 256,
  parameter int          DATA_WIDTH   = 32,
  parameter logic [31:0] BASE_ADDRESS = DEFAULT_BASE_ADDRESS,
  localparam int         CNT_W        = $clog2(MEMORY_DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start_i,
  input  logic [7:0]            rx_data_i,
  input  logic                  rx_valid_i,
  output logic                  rx_ready_o,
  output logic                  mem_we_o,
  output logic [DATA_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_data_o,
  output logic                  cpu_hold_o,
  output logic                  done_o,
  output logic                  error_o,
  output logic [CNT_W-1:0]      words_loaded_o
);

  state_e                state_q, state_d;
  logic [15:0]           count_q, count_d;
  logic [7:0]            csum_q, csum_d;
  logic [CNT_W-1:0]      idx_q, idx_d;
  logic [DATA_WIDTH-1:0] addr_q, addr_d;

  logic        accept;
  logic        start_ok;
  logic        data_byte;
  logic        asm_last;
  logic        asm_valid;
  logic [15:0] count_n;
  logic        last_word;

  assign rx_ready_o = (state_q == ST_COUNT_HI) || (state_q == ST_COUNT_LO) ||
                      (state_q == ST_DATA)     || (state_q == ST_CHECK);
  assign accept     = rx_valid_i && rx_ready_o;
  assign start_ok   = start_i && ((state_q == ST_IDLE) || (state_q == ST_DONE) ||
                                  (state_q == ST_ERROR));
  assign data_byte  = accept && (state_q == ST_DATA);
  assign count_n    = {count_q[15:8], rx_data_i};
  assign last_word  = (16'(idx_q) + 16'd1 == count_q);

  byte_word_assembler #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_assembler (
    .clk         (clk),
    .reset       (reset),
    .clear_i     (start_ok),
    .byte_valid_i(data_byte),
    .byte_i      (rx_data_i),
    .last_byte_o (asm_last),
    .word_valid_o(asm_valid),
    .word_o      (mem_data_o)
  );

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    csum_d  = csum_q;
    idx_d   = idx_q;
    addr_d  = addr_q;
    if (start_ok) begin
      state_d = ST_COUNT_HI;
      count_d = '0;
      csum_d  = '0;
      idx_d   = '0;
    end else if (accept) begin
      unique case (state_q)
        ST_COUNT_HI: begin
          count_d[15:8] = rx_data_i;
          csum_d        = csum_q ^ rx_data_i;
          state_d       = ST_COUNT_LO;
        end
        ST_COUNT_LO: begin
          count_d = count_n;
          csum_d  = csum_q ^ rx_data_i;
          if (count_n == 16'd0)                    state_d = ST_CHECK;
          else if (count_n > 16'(MEMORY_DEPTH))    state_d = ST_ERROR;
          else                                     state_d = ST_DATA;
        end
        ST_DATA: begin
          csum_d = csum_q ^ rx_data_i;
          if (asm_last) begin
            // Address uses the pre-increment index; both land on the edge that raises mem_we_o.
            addr_d = BASE_ADDRESS + (DATA_WIDTH'(idx_q) << 2);
            idx_d  = idx_q + CNT_W'(1);
            if (last_word) state_d = ST_CHECK;
          end
        end
        ST_CHECK: state_d = (rx_data_i == csum_q) ? ST_DONE : ST_ERROR;
        default:  state_d = state_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      count_q <= '0;
      csum_q  <= '0;
      idx_q   <= '0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      csum_q  <= csum_d;
      idx_q   <= idx_d;
      addr_q  <= addr_d;
    end
  end

  assign mem_we_o       = asm_valid;
  assign mem_addr_o     = addr_q;
  assign done_o         = (state_q == ST_DONE);
  assign error_o        = (state_q == ST_ERROR);
  assign cpu_hold_o     = (state_q != ST_DONE);
  assign words_loaded_o = idx_q;

endmodule

// File: tb/tb_program_memory_loader.sv
// Randomized self-checking bench for program_memory_loader against an image-level reference model.
module tb_program_memory_loader;

  localparam logic [31:0] BASE = 32'h0040_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        start_i;
  logic [7:0]  rx_data_i;
  logic        rx_valid_i;
  logic        rx_ready_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_data_o;
  logic        cpu_hold_o;
  logic        done_o;
  logic        error_o;
  logic [8:0]  words_loaded_o;

  int vectors     = 0;
  int miscompares = 0;

  logic [31:0] img_words[$];
  logic [31:0] wr_addr_q[$];
  logic [31:0] wr_data_q[$];

  program_memory_loader dut (
    .clk           (clk),
    .reset         (reset),
    .start_i       (start_i),
    .rx_data_i     (rx_data_i),
    .rx_valid_i    (rx_valid_i),
    .rx_ready_o    (rx_ready_o),
    .mem_we_o      (mem_we_o),
    .mem_addr_o    (mem_addr_o),
    .mem_data_o    (mem_data_o),
    .cpu_hold_o    (cpu_hold_o),
    .done_o        (done_o),
    .error_o       (error_o),
    .words_loaded_o(words_loaded_o)
  );

  always #5 clk = ~clk;

  // Write monitor: a strobe longer than one cycle shows up as extra entries.
  always @(negedge clk) begin
    if (mem_we_o) begin
      wr_addr_q.push_back(mem_addr_o);
      wr_data_q.push_back(mem_data_o);
    end
  end

  task automatic apply_reset();
    reset      = 1'b1;
    start_i    = 1'b0;
    rx_valid_i = 1'b0;
    rx_data_i  = 8'h00;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    wr_addr_q.delete();
    wr_data_q.delete();
    @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string name);
    vectors++;
    if ({rx_ready_o, mem_we_o, mem_addr_o, mem_data_o, cpu_hold_o, done_o, error_o, words_loaded_o} !==
        {1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 9'd0}) begin
      miscompares++;
      $display("FAIL %s: rdy=%b we=%b addr=%h data=%h hold=%b done=%b err=%b words=%0d, required 0 0 0 0 1 0 0 0",
               name, rx_ready_o, mem_we_o, mem_addr_o, mem_data_o, cpu_hold_o, done_o, error_o, words_loaded_o);
    end
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
  endtask

  // Called at a negedge; returns at the negedge after the byte was accepted.
  task automatic send_byte(input logic [7:0] b, input int max_gap);
    int g = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
    int waited = 0;
    rx_valid_i = 1'b0;
    repeat (g) begin
      rx_data_i = 8'($urandom);
      @(negedge clk);
    end
    rx_valid_i = 1'b1;
    rx_data_i  = b;
    while (!rx_ready_o && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (!rx_ready_o) begin
      vectors++;
      miscompares++;
      $display("FAIL send_byte_timeout: rx_ready_o stayed %b for %0d cycles, required 1", rx_ready_o, waited);
    end
    @(negedge clk);
  endtask

  task automatic run_image(input logic [7:0] chk_flip, input int max_gap, input string name);
    logic [7:0]  bytes_q[$];
    logic [7:0]  chk = 8'h00;
    logic [15:0] n16 = 16'(img_words.size());
    logic [31:0] w;
    bit          good = (chk_flip == 8'h00);
    bytes_q.push_back(n16[15:8]);
    bytes_q.push_back(n16[7:0]);
    foreach (img_words[i]) begin
      w = img_words[i];
      bytes_q.push_back(w[31:24]);
      bytes_q.push_back(w[23:16]);
      bytes_q.push_back(w[15:8]);
      bytes_q.push_back(w[7:0]);
    end
    foreach (bytes_q[i]) chk ^= bytes_q[i];
    bytes_q.push_back(chk ^ chk_flip);

    pulse_start();
    wr_addr_q.delete();
    wr_data_q.delete();
    vectors++;
    if ({cpu_hold_o, done_o, error_o, words_loaded_o, rx_ready_o} !== {1'b1, 1'b0, 1'b0, 9'd0, 1'b1}) begin
      miscompares++;
      $display("FAIL %s_after_start: hold=%b done=%b err=%b words=%0d rdy=%b, required 1 0 0 0 1",
               name, cpu_hold_o, done_o, error_o, words_loaded_o, rx_ready_o);
    end

    foreach (bytes_q[i]) send_byte(bytes_q[i], max_gap);
    rx_valid_i = 1'b0;
    repeat (3) @(negedge clk);

    vectors++;
    if (wr_addr_q.size() != img_words.size()) begin
      miscompares++;
      $display("FAIL %s_write_count: got %0d writes, required %0d", name, wr_addr_q.size(), img_words.size());
    end else begin
      foreach (img_words[i]) begin
        vectors++;
        if (wr_addr_q[i] !== BASE + 32'(i) * 32'd4 || wr_data_q[i] !== img_words[i]) begin
          miscompares++;
          $display("FAIL %s_write[%0d]: got (%h,%h), required (%h,%h)", name, i,
                   wr_addr_q[i], wr_data_q[i], BASE + 32'(i) * 32'd4, img_words[i]);
        end
      end
    end

    vectors++;
    if ({done_o, error_o, cpu_hold_o, rx_ready_o, words_loaded_o} !== {good, !good, !good, 1'b0, 9'(img_words.size())}) begin
      miscompares++;
      $display("FAIL %s_final: done=%b err=%b hold=%b rdy=%b words=%0d, required %b %b %b 0 %0d", name,
               done_o, error_o, cpu_hold_o, rx_ready_o, words_loaded_o, good, !good, !good, img_words.size());
    end
  endtask

  task automatic test_reset();
    apply_reset();
    check_reset_outputs("reset_state");
    repeat (5) begin
      rx_valid_i = 1'b1;
      rx_data_i  = 8'($urandom);
      @(negedge clk);
    end
    rx_valid_i = 1'b0;
    @(negedge clk);
    check_reset_outputs("idle_ignores_bytes");
    vectors++;
    if (wr_addr_q.size() != 0) begin
      miscompares++;
      $display("FAIL idle_no_writes: got %0d writes, required 0", wr_addr_q.size());
    end
  endtask

  task automatic test_directed();
    img_words = '{32'h2008_0005, 32'h0109_5020};
    run_image(8'h00, 0, "directed_good");
    run_image(8'h5A, 0, "directed_bad_chk");
  endtask

  task automatic test_overflow();
    pulse_start();
    wr_addr_q.delete();
    wr_data_q.delete();
    send_byte(8'h01, 0);
    send_byte(8'h01, 0);
    rx_valid_i = 1'b0;
    vectors++;
    if ({error_o, rx_ready_o, done_o, cpu_hold_o} !== 4'b1001) begin
      miscompares++;
      $display("FAIL overflow_257: err=%b rdy=%b done=%b hold=%b, required 1 0 0 1",
               error_o, rx_ready_o, done_o, cpu_hold_o);
    end
    repeat (4) @(negedge clk);
    vectors++;
    if (wr_addr_q.size() != 0) begin
      miscompares++;
      $display("FAIL overflow_no_writes: got %0d writes, required 0", wr_addr_q.size());
    end

    img_words.delete();
    for (int i = 0; i < 256; i++) img_words.push_back($urandom);
    run_image(8'h00, 0, "full_256");
    vectors++;
    if (wr_addr_q.size() == 0 || wr_addr_q[wr_addr_q.size() - 1] !== 32'h0040_03FC) begin
      miscompares++;
      $display("FAIL full_256_last_addr: got %h, required 004003fc",
               (wr_addr_q.size() == 0) ? 32'hx : wr_addr_q[wr_addr_q.size() - 1]);
    end
  endtask

  task automatic test_zero_count();
    img_words.delete();
    run_image(8'h00, 1, "zero_good");
    run_image(8'h01, 1, "zero_bad");
  endtask

  task automatic test_reset_mid_load();
    img_words = '{32'hDEAD_BEEF, 32'h1234_5678, 32'hCAFE_F00D};
    pulse_start();
    wr_addr_q.delete();
    wr_data_q.delete();
    send_byte(8'h00, 0);
    send_byte(8'h03, 0);
    send_byte(8'hDE, 0);
    send_byte(8'hAD, 0);
    send_byte(8'hBE, 0);
    send_byte(8'hEF, 0);
    send_byte(8'h12, 0);
    send_byte(8'h34, 0);
    rx_valid_i = 1'b0;
    reset = 1'b1;
    #1;
    check_reset_outputs("reset_mid_load");
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    vectors++;
    if (wr_addr_q.size() != 1) begin
      miscompares++;
      $display("FAIL reset_mid_writes: got %0d writes, required 1 (word 0 only)", wr_addr_q.size());
    end
    run_image(8'h00, 1, "reload_after_reset");
  endtask

  task automatic test_random();
    for (int t = 0; t < 6; t++) begin
      img_words.delete();
      for (int i = 0; i < int'($urandom_range(1, 8)); i++) img_words.push_back($urandom);
      run_image(($urandom_range(0, 2) == 0) ? 8'(1 << $urandom_range(0, 7)) : 8'h00, 2, "random");
    end
  endtask

  initial begin
    reset      = 1'b1;
    start_i    = 1'b0;
    rx_valid_i = 1'b0;
    rx_data_i  = 8'h00;
    test_reset();
    test_directed();
    test_overflow();
    test_zero_count();
    test_reset_mid_load();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
